// File: rtl/adsr_envelope.sv
// Per-voice ADSR envelope generator: gate edges move the stage immediately,
// level steps by power-of-two amounts on a prescaled tick and saturates to 16 bits.
module adsr_envelope #(
    parameter int unsigned PRESCALE = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        gate,
    input  logic [3:0]  attack_rate,
    input  logic [3:0]  decay_rate,
    input  logic [3:0]  sustain_lvl,
    input  logic [3:0]  release_rate,
    output logic [15:0] level,
    output logic [3:0]  vol,
    output logic [2:0]  state,
    output logic        busy
);

    localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ATTACK  = 3'd1,
        S_DECAY   = 3'd2,
        S_SUSTAIN = 3'd3,
        S_RELEASE = 3'd4
    } state_e;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          gate_prev_q, gate_prev_d;
    state_e        state_q, state_d;
    logic [15:0]   level_q, level_d;
    logic          busy_q, busy_d;

    logic          tick_s, rise_s, fall_s;
    logic [15:0]   target_s;
    logic [3:0]    down_rate_s;
    logic [16:0]   sum_s;
    logic [17:0]   diff_s;

    // Prescaler and gate edge detection.
    always_comb begin
        tick_s      = (cnt_q == CNT_MAX);
        if (tick_s) begin
            cnt_d = {CW{1'b0}};
        end else begin
            cnt_d = cnt_q + CW'(1'b1);
        end
        gate_prev_d = gate;
        rise_s      = gate & ~gate_prev_q;
        fall_s      = ~gate & gate_prev_q;
    end

    // Envelope arithmetic and stage transitions; gate events override the tick.
    always_comb begin
        target_s    = {4{sustain_lvl}};
        down_rate_s = (state_q == S_RELEASE) ? release_rate : decay_rate;
        sum_s       = {1'b0, level_q} + (17'd1 << attack_rate);
        // Bit 17 set means the subtraction went below zero.
        diff_s      = {2'b00, level_q} - (18'd1 << down_rate_s);
        state_d     = state_q;
        level_d     = level_q;

        if (rise_s) begin
            state_d = S_ATTACK;
        end else if (fall_s && (state_q == S_ATTACK || state_q == S_DECAY ||
                                state_q == S_SUSTAIN)) begin
            state_d = S_RELEASE;
        end else if (tick_s) begin
            case (state_q)
                S_ATTACK: begin
                    if (sum_s >= 17'h0FFFF) begin
                        level_d = 16'hFFFF;
                        state_d = S_DECAY;
                    end else begin
                        level_d = sum_s[15:0];
                    end
                end
                S_DECAY: begin
                    if (diff_s[17] || (diff_s[16:0] <= {1'b0, target_s})) begin
                        level_d = target_s;
                        state_d = S_SUSTAIN;
                    end else begin
                        level_d = diff_s[15:0];
                    end
                end
                S_SUSTAIN: begin
                    level_d = target_s;
                end
                S_RELEASE: begin
                    if (diff_s[17] || (diff_s[16:0] == 17'd0)) begin
                        level_d = 16'h0000;
                        state_d = S_IDLE;
                    end else begin
                        level_d = diff_s[15:0];
                    end
                end
                S_IDLE: begin
                    level_d = 16'h0000;
                end
                default: begin
                    level_d = 16'h0000;
                    state_d = S_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        busy_d = (state_d != S_IDLE);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= {CW{1'b0}};
            gate_prev_q <= 1'b0;
            state_q     <= S_IDLE;
            level_q     <= 16'h0000;
            busy_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            gate_prev_q <= gate_prev_d;
            state_q     <= state_d;
            level_q     <= level_d;
            busy_q      <= busy_d;
        end
    end

    assign level = level_q;
    assign vol   = level_q[15:12];
    assign state = state_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_adsr_envelope.sv
// Self-checking bench for adsr_envelope: directed stage scenarios plus
// randomized gate/rate/reset traffic against an integer reference model.
module tb_adsr_envelope;

    localparam int PRE = 4;

    logic        clk;
    logic        rst;
    logic        gate;
    logic [3:0]  ar, dr, sl, rr;
    logic [15:0] level;
    logic [3:0]  vol;
    logic [2:0]  state;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: envelope described as plain integers.
    int m_cnt  = 0;
    int m_gd   = 0;
    int m_st   = 0;
    int m_lvl  = 0;
    bit m_tick_last = 1'b0;

    adsr_envelope #(.PRESCALE(PRE)) dut (
        .clk          (clk),
        .rst          (rst),
        .gate         (gate),
        .attack_rate  (ar),
        .decay_rate   (dr),
        .sustain_lvl  (sl),
        .release_rate (rr),
        .level        (level),
        .vol          (vol),
        .state        (state),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; the model predicts the post-edge outputs.
    task automatic step();
        int  tgt, nst, nlvl, d;
        bit  tick, rise, fall;
        tick = 1'b0;
        if (rst) begin
            nst = 0; nlvl = 0;
        end else begin
            tick = (m_cnt == PRE - 1);
            rise = gate && (m_gd == 0);
            fall = !gate && (m_gd == 1);
            tgt  = int'(sl) * 4369;
            nst  = m_st;
            nlvl = m_lvl;
            if (rise) begin
                nst = 1;
            end else if (fall && m_st >= 1 && m_st <= 3) begin
                nst = 4;
            end else if (tick) begin
                if (m_st == 1) begin
                    d = m_lvl + (1 << ar);
                    if (d >= 65535) begin nlvl = 65535; nst = 2; end
                    else nlvl = d;
                end else if (m_st == 2) begin
                    d = m_lvl - (1 << dr);
                    if (d <= tgt) begin nlvl = tgt; nst = 3; end
                    else nlvl = d;
                end else if (m_st == 3) begin
                    nlvl = tgt;
                end else if (m_st == 4) begin
                    d = m_lvl - (1 << rr);
                    if (d <= 0) begin nlvl = 0; nst = 0; end
                    else nlvl = d;
                end else begin
                    nlvl = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        if (rst) begin
            m_cnt = 0; m_gd = 0;
        end else begin
            m_cnt = (m_cnt + 1) % PRE;
            m_gd  = gate ? 1 : 0;
        end
        m_st  = nst;
        m_lvl = nlvl;
        m_tick_last = tick;
    endtask

    // Step until the cycle just completed was a tick cycle.
    task automatic run_to_tick();
        for (int i = 0; i < 2 * PRE; i++) begin
            step();
            if (m_tick_last) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; gate = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if ({level, state, busy} !== {16'h0000, 3'd0, 1'b0}) begin
                n_fail++;
                $display("FAIL reset_hold cyc%0d level=%h state=%0d busy=%b exp 0/0/0", i, level, state, busy);
            end
        end
        rst = 1'b0;
        step();
        n_checks++;
        if ({level, state, busy} !== {16'h0000, 3'd1, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_release level=%h state=%0d busy=%b exp 0000/1/1", level, state, busy);
        end
    endtask

    task automatic test_full_adsr();
        run_to_tick();
        n_checks++;
        if ({state, level} !== {3'd1, 16'h8000}) begin
            n_fail++; $display("FAIL adsr_attack1 state=%0d level=%h exp 1/8000", state, level);
        end
        run_to_tick();
        n_checks++;
        if ({state, level} !== {3'd2, 16'hFFFF}) begin
            n_fail++; $display("FAIL adsr_attack2 state=%0d level=%h exp 2/ffff", state, level);
        end
        run_to_tick();
        n_checks++;
        if ({state, level} !== {3'd2, 16'hBFFF}) begin
            n_fail++; $display("FAIL adsr_decay1 state=%0d level=%h exp 2/bfff", state, level);
        end
        run_to_tick();
        n_checks++;
        if ({state, level, vol} !== {3'd3, 16'h8888, 4'd8}) begin
            n_fail++; $display("FAIL adsr_decay2 state=%0d level=%h vol=%0d exp 3/8888/8", state, level, vol);
        end
        gate = 1'b0;
        step();
        n_checks++;
        if ({state, level} !== {3'd4, 16'h8888}) begin
            n_fail++; $display("FAIL adsr_gate_off state=%0d level=%h exp 4/8888", state, level);
        end
        run_to_tick();
        n_checks++;
        if ({state, level} !== {3'd4, 16'h0888}) begin
            n_fail++; $display("FAIL adsr_release1 state=%0d level=%h exp 4/0888", state, level);
        end
        run_to_tick();
        n_checks++;
        if ({state, level, busy} !== {3'd0, 16'h0000, 1'b0}) begin
            n_fail++; $display("FAIL adsr_release2 state=%0d level=%h busy=%b exp 0/0000/0", state, level, busy);
        end
    endtask

    task automatic test_sustain_limits();
        gate = 1'b1; ar = 4'd15; dr = 4'd14; sl = 4'd15;
        step();
        run_to_tick();
        run_to_tick();
        n_checks++;
        if ({state, level} !== {3'd2, 16'hFFFF}) begin
            n_fail++; $display("FAIL sus15_peak state=%0d level=%h exp 2/ffff", state, level);
        end
        run_to_tick();
        n_checks++;
        if ({state, level} !== {3'd3, 16'hFFFF}) begin
            n_fail++; $display("FAIL sus15_decay state=%0d level=%h exp 3/ffff", state, level);
        end
        gate = 1'b0; step();
        gate = 1'b1; step();
        sl = 4'd0; dr = 4'd15;
        run_to_tick();
        n_checks++;
        if ({state, level} !== {3'd2, 16'hFFFF}) begin
            n_fail++; $display("FAIL sus0_peak state=%0d level=%h exp 2/ffff", state, level);
        end
        run_to_tick();
        n_checks++;
        if ({state, level} !== {3'd2, 16'h7FFF}) begin
            n_fail++; $display("FAIL sus0_decay1 state=%0d level=%h exp 2/7fff", state, level);
        end
        run_to_tick();
        n_checks++;
        if ({state, level, busy} !== {3'd3, 16'h0000, 1'b1}) begin
            n_fail++; $display("FAIL sus0_decay2 state=%0d level=%h busy=%b exp 3/0000/1", state, level, busy);
        end
    endtask

    task automatic test_retrigger();
        gate = 1'b0; step();
        gate = 1'b1; step();
        ar = 4'd14;
        run_to_tick();
        gate = 1'b0; step();
        n_checks++;
        if ({state, level} !== {3'd4, 16'h4000}) begin
            n_fail++; $display("FAIL retrig_release state=%0d level=%h exp 4/4000", state, level);
        end
        gate = 1'b1; step();
        n_checks++;
        if ({state, level} !== {3'd1, 16'h4000}) begin
            n_fail++; $display("FAIL retrig_edge state=%0d level=%h exp 1/4000", state, level);
        end
        ar = 4'd12;
        run_to_tick();
        n_checks++;
        if ({state, level} !== {3'd1, 16'h5000}) begin
            n_fail++; $display("FAIL retrig_attack state=%0d level=%h exp 1/5000", state, level);
        end
    endtask

    task automatic test_edge_on_tick();
        rst = 1'b1; step();
        rst = 1'b0; gate = 1'b1; ar = 4'd12; rr = 4'd12;
        step();
        for (int i = 0; i < 3; i++) run_to_tick();
        for (int i = 0; i < PRE && m_cnt != PRE - 1; i++) step();
        gate = 1'b0;
        step();
        n_checks++;
        if ({state, level, m_tick_last} !== {3'd4, 16'h3000, 1'b1}) begin
            n_fail++; $display("FAIL edge_tick state=%0d level=%h tick=%b exp 4/3000/1", state, level, m_tick_last);
        end
        run_to_tick();
        n_checks++;
        if ({state, level} !== {3'd4, 16'h2000}) begin
            n_fail++; $display("FAIL edge_tick_next state=%0d level=%h exp 4/2000", state, level);
        end
    endtask

    task automatic test_sustain_follow();
        gate = 1'b1; ar = 4'd15; dr = 4'd15; sl = 4'd8;
        step();
        for (int i = 0; i < 3; i++) run_to_tick();
        n_checks++;
        if ({state, level} !== {3'd3, 16'h8888}) begin
            n_fail++; $display("FAIL follow_start state=%0d level=%h exp 3/8888", state, level);
        end
        sl = 4'd4;
        run_to_tick();
        n_checks++;
        if ({state, level, vol} !== {3'd3, 16'h4444, 4'd4}) begin
            n_fail++; $display("FAIL follow_change state=%0d level=%h vol=%0d exp 3/4444/4", state, level, vol);
        end
    endtask

    task automatic test_random();
        logic [15:0] e_lvl;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 29) == 0) gate = ~gate;
            if ($urandom_range(0, 49) == 0) begin
                ar = 4'($urandom_range(6, 15));
                dr = 4'($urandom_range(6, 15));
                rr = 4'($urandom_range(6, 15));
                sl = 4'($urandom_range(0, 15));
            end
            rst = ($urandom_range(0, 799) == 0);
            step();
            e_lvl = 16'(m_lvl);
            n_checks++;
            if ({level, vol, state, busy} !== {e_lvl, e_lvl[15:12], 3'(m_st), (m_st != 0)}) begin
                n_fail++;
                $display("FAIL random cyc%0d level=%h state=%0d busy=%b exp %h/%0d/%b",
                         i, level, state, busy, e_lvl, m_st, (m_st != 0));
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; gate = 1'b0;
        ar = 4'd15; dr = 4'd14; sl = 4'd8; rr = 4'd15;
        test_reset();
        test_full_adsr();
        test_sustain_limits();
        test_retrigger();
        test_edge_on_tick();
        test_sustain_follow();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
